ahblite_sram_slave: RTL

- AHB-Lite responder fronting a single-port synchronous SRAM (1-cycle read latency, per-byte write enables).
- Terminates the data bus driven by the core's load/store unit.
- Zero-wait-state reads and writes in the common case.
- One wait state for a read issued in the address phase while a write data phase is in progress.
- Two-cycle AHB ERROR response for illegal transfers.

---
 rtl/ahblite_sram_slave_pkg.sv | 39 +++
 rtl/ahblite_sram_slave.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ahblite_sram_slave_pkg.sv
// Shared AHB-Lite core definitions: transfer/size/response codes, the SRAM
// slave state encoding and the byte-enable decode also used by the LSU.
package ahblite_sram_slave_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_DP    = 3'd1,
    ST_RD_DP    = 3'd2,
    ST_RD_STALL = 3'd3,
    ST_ERR1     = 3'd4,
    ST_ERR2     = 3'd5
  } state_t;

  // Lane enables for a 32-bit bus; unsupported sizes enable nothing.
  function automatic logic [3:0] byte_enables(input logic [2:0] size,
                                              input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      HSIZE_BYTE: be = 4'b0001 << addr_lo;
      HSIZE_HALF: be = 4'b0011 << addr_lo;
      HSIZE_WORD: be = 4'b1111;
      default:    be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/ahblite_sram_slave.sv
// AHB-Lite responder in front of a single-port synchronous SRAM: zero-wait
// reads and writes, one stall for a read behind a write, two-cycle ERROR.
module ahblite_sram_slave
  import ahblite_sram_slave_pkg::*;
#(
  parameter int                 HADDR_W   = 32,
  parameter int                 RAM_AW    = 14,
  parameter logic [HADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hsel,
  input  logic [HADDR_W-1:0] haddr,
  input  logic [1:0]         htrans,
  input  logic               hwrite,
  input  logic [2:0]         hsize,
  input  logic [2:0]         hburst,
  input  logic [3:0]         hprot,
  input  logic               hmastlock,
  input  logic               hready,
  input  logic [31:0]        hwdata,
  output logic               hreadyout,
  output logic               hresp,
  output logic [31:0]        hrdata,
  output logic               ram_en,
  output logic [3:0]         ram_we,
  output logic [RAM_AW-1:0]  ram_addr,
  output logic [31:0]        ram_wdata,
  input  logic [31:0]        ram_rdata
);

  localparam int OFF_W = RAM_AW + 2;

  state_t           state;
  state_t           state_next;
  logic [OFF_W-1:0] addr_reg;
  logic [2:0]       size_reg;
  logic             write_reg;

  logic acc;
  logic ready;
  logic take;
  logic in_range;
  logic size_ok;
  logic aligned;
  logic legal;
  logic unused_inputs;

  assign unused_inputs = ^{hburst, hprot, hmastlock, htrans[0]};

  // Only states that finish a data phase this cycle can accept a new address.
  assign ready = (state != ST_RD_STALL) && (state != ST_ERR1);
  assign acc   = hsel & hready & htrans[1];
  assign take  = acc & ready;

  assign in_range = (haddr[HADDR_W-1:OFF_W] == BASE_ADDR[HADDR_W-1:OFF_W]);
  assign size_ok  = (hsize <= HSIZE_WORD);

  always_comb begin
    aligned = 1'b1;
    case (hsize)
      HSIZE_HALF: aligned = ~haddr[0];
      HSIZE_WORD: aligned = (haddr[1:0] == 2'b00);
      default:    aligned = 1'b1;
    endcase
  end

  assign legal = size_ok & aligned & in_range;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg  <= '0;
      size_reg  <= '0;
      write_reg <= 1'b0;
    end else if (take && legal) begin
      addr_reg  <= haddr[OFF_W-1:0];
      size_reg  <= hsize;
      write_reg <= hwrite;
    end
  end

  always_comb begin
    state_next = ST_IDLE;
    case (state)
      ST_RD_STALL: state_next = ST_RD_DP;
      ST_ERR1:     state_next = ST_ERR2;
      default: begin
        if (take) begin
          if (!legal) begin
            state_next = ST_ERR1;
          end else if (hwrite) begin
            state_next = ST_WR_DP;
          end else if (state == ST_WR_DP) begin
            // The port is committing the write this cycle; issue the read next.
            state_next = ST_RD_STALL;
          end else begin
            state_next = ST_RD_DP;
          end
        end
      end
    endcase
  end

  always_comb begin
    hreadyout = ready;
    hresp     = HRESP_OKAY;
    hrdata    = '0;
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = '0;
    ram_wdata = '0;

    case (state)
      ST_WR_DP: begin
        ram_en    = 1'b1;
        ram_we    = write_reg ? byte_enables(size_reg, addr_reg[1:0]) : 4'b0000;
        ram_addr  = addr_reg[OFF_W-1:2];
        ram_wdata = hwdata;
      end
      ST_RD_DP: begin
        hrdata = ram_rdata;
      end
      ST_RD_STALL: begin
        ram_en   = 1'b1;
        ram_addr = addr_reg[OFF_W-1:2];
      end
      ST_ERR1, ST_ERR2: begin
        hresp = HRESP_ERROR;
      end
      default: ;
    endcase

    // Zero-wait read: present the address to the SRAM during the address phase.
    if (take && legal && !hwrite && (state != ST_WR_DP)) begin
      ram_en   = 1'b1;
      ram_we   = 4'b0000;
      ram_addr = haddr[OFF_W-1:2];
    end
  end

endmodule
